gb_host_bridge: RTL and testbench

GB_HOST_BRIDGE -- requirements
Module: gb_host_bridge

---
 rtl/gb_pkg.sv | 16 +
 rtl/gb_host_bridge_if.sv | 34 +++
 rtl/gb_host_bridge.sv | 101 ++++++++++
 tb/tb_gb_host_bridge.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/gb_pkg.sv
// gb_pkg -- shared definitions for the ghostbus host bridge.
//   gb_state_e     : bridge FSM states
//   GB_RD_LAT_MIN/MAX : legal range of the read-latency parameter
package gb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } gb_state_e;

  localparam int GB_RD_LAT_MIN = 1;
  localparam int GB_RD_LAT_MAX = 7;

endpackage

// File: rtl/gb_host_bridge_if.sv
// gb_host_bridge_if -- host request/response channel plus ghostbus signals.
//   slave  : bridge view (accepts requests, drives ghostbus)
//   master : host + peripheral view (offers requests, returns gb_din)
interface gb_host_bridge_if #(
  parameter int AW = 24,
  parameter int DW = 32
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_dout;
  logic [DW-1:0] gb_din;
  logic          gb_we;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, gb_din,
    output req_ready, rsp_valid, rsp_we, rsp_rdata, busy, gb_addr, gb_dout, gb_we
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, gb_din,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata, busy, gb_addr, gb_dout, gb_we
  );

endinterface

// File: rtl/gb_host_bridge.sv
// gb_host_bridge -- single-outstanding host to ghostbus bridge.
//   clk   : bus clock
//   rst_n : synchronous active-low reset
//   bus   : gb_host_bridge_if.slave (request/response handshake and ghostbus)
//
// state | meaning
// IDLE  | ready for a request
// WR    | gb_we strobe cycle
// RD    | waiting RD_LAT cycles for gb_din
// RESP  | response held until rsp_ready
module gb_host_bridge
  import gb_pkg::*;
#(
  parameter int AW     = 24,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input logic              clk,
  input logic              rst_n,
  gb_host_bridge_if.slave  bus
);

  if (RD_LAT < GB_RD_LAT_MIN || RD_LAT > GB_RD_LAT_MAX) begin : g_bad_rd_lat
    $error("gb_host_bridge: RD_LAT must be within 1..7");
  end

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  gb_state_e     state_q;
  logic [2:0]    cnt_q;
  logic [AW-1:0] gb_addr_q;
  logic [DW-1:0] gb_dout_q;
  logic          gb_we_q;
  logic          rsp_valid_q;
  logic          rsp_we_q;
  logic [DW-1:0] rsp_rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gb_addr_q   <= '0;
      gb_dout_q   <= '0;
      gb_we_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // req_ready is high throughout IDLE once out of reset
          if (bus.req_valid) begin
            gb_addr_q <= bus.req_addr;
            rsp_we_q  <= bus.req_we;
            cnt_q     <= '0;
            if (bus.req_we) begin
              gb_dout_q <= bus.req_wdata;
              gb_we_q   <= 1'b1;
              state_q   <= WR;
            end else begin
              state_q   <= RD;
            end
          end
        end
        WR: begin
          gb_we_q     <= 1'b0;
          rsp_rdata_q <= '0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RD: begin
          // first RD edge brings the count to 1; data taken once it reaches RD_LAT
          if (cnt_q == RD_LAT_C) begin
            rsp_rdata_q <= bus.gb_din;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE) && rst_n;
  assign bus.busy      = (state_q != IDLE);
  assign bus.gb_addr   = gb_addr_q;
  assign bus.gb_dout   = gb_dout_q;
  assign bus.gb_we     = gb_we_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_we    = rsp_we_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_gb_host_bridge.sv
// tb_gb_host_bridge -- directed bench for gb_host_bridge.
//   Two bridges share clk/rst_n: b2 with RD_LAT=2, b7 with RD_LAT=7.
//   The peripheral model returns valid data only once RD_LAT cycles have
//   passed since the accept edge, otherwise a poison word.
module tb_gb_host_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   we_cnt2 = 0;
  int   rsp_cnt2 = 0;
  int   age2 = 100;
  int   age7 = 100;

  always #5 clk = ~clk;

  gb_host_bridge_if #(.AW(24), .DW(32)) b2 ();
  gb_host_bridge_if #(.AW(24), .DW(32)) b7 ();

  gb_host_bridge #(.AW(24), .DW(32), .RD_LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  gb_host_bridge #(.AW(24), .DW(32), .RD_LAT(7)) dut7 (.clk(clk), .rst_n(rst_n), .bus(b7));

  function automatic logic [31:0] pdata(input logic [23:0] a);
    return (a == 24'h000004) ? 32'h0000_00CC : {8'hA5, a};
  endfunction

  always @(posedge clk) begin
    if (b2.req_valid && b2.req_ready) age2 <= 0;
    else if (age2 < 100) age2 <= age2 + 1;
    if (b7.req_valid && b7.req_ready) age7 <= 0;
    else if (age7 < 100) age7 <= age7 + 1;
    if (b2.gb_we) we_cnt2 <= we_cnt2 + 1;
    if (b2.rsp_valid && b2.rsp_ready) rsp_cnt2 <= rsp_cnt2 + 1;
  end

  assign b2.gb_din = (age2 >= 2) ? pdata(b2.gb_addr) : 32'hBAD0_BAD0;
  assign b7.gb_din = (age7 >= 7) ? pdata(b7.gb_addr) : 32'hBAD0_BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req2(input logic we, input logic [23:0] a, input logic [31:0] d);
    b2.req_valid = 1'b1;
    b2.req_we    = we;
    b2.req_addr  = a;
    b2.req_wdata = d;
  endtask

  initial begin
    int we_base;
    int rsp_base;
    b2.req_valid = 0; b2.req_we = 0; b2.req_addr = '0; b2.req_wdata = '0; b2.rsp_ready = 0;
    b7.req_valid = 0; b7.req_we = 0; b7.req_addr = '0; b7.req_wdata = '0; b7.rsp_ready = 0;
    repeat (3) tick();

    check("rst_req_ready", 32'(b2.req_ready), 32'd0);
    check("rst_busy", 32'(b2.busy), 32'd0);
    check("rst_gb_we", 32'(b2.gb_we), 32'd0);
    check("rst_rsp_valid", 32'(b2.rsp_valid), 32'd0);
    check("rst_gb_addr", 32'(b2.gb_addr), 32'd0);
    check("rst_rsp_rdata", b2.rsp_rdata, 32'd0);

    rst_n = 1'b1;
    tick();
    check("post_rst_req_ready", 32'(b2.req_ready), 32'd1);

    // single write
    req2(1'b1, 24'h000100, 32'hCECE_FACE);
    tick();
    b2.req_valid = 1'b0;
    check("wr_gb_we", 32'(b2.gb_we), 32'd1);
    check("wr_gb_addr", 32'(b2.gb_addr), 32'h000100);
    check("wr_gb_dout", b2.gb_dout, 32'hCECE_FACE);
    check("wr_busy", 32'(b2.busy), 32'd1);
    check("wr_req_ready", 32'(b2.req_ready), 32'd0);
    tick();
    check("wr_gb_we_off", 32'(b2.gb_we), 32'd0);
    check("wr_rsp_valid", 32'(b2.rsp_valid), 32'd1);
    check("wr_rsp_we", 32'(b2.rsp_we), 32'd1);
    check("wr_rsp_rdata", b2.rsp_rdata, 32'd0);
    b2.rsp_ready = 1'b1;
    tick();
    b2.rsp_ready = 1'b0;
    check("wr_rsp_done", 32'(b2.rsp_valid), 32'd0);
    check("wr_idle_ready", 32'(b2.req_ready), 32'd1);
    check("wr_pulse_count", 32'(we_cnt2), 32'd1);
    check("wr_rsp_count", 32'(rsp_cnt2), 32'd1);

    // read, RD_LAT=2
    req2(1'b0, 24'h000004, 32'h0);
    tick();
    b2.req_valid = 1'b0;
    check("rd_gb_addr", 32'(b2.gb_addr), 32'h000004);
    check("rd_gb_dout_held", b2.gb_dout, 32'hCECE_FACE);
    check("rd_no_we", 32'(b2.gb_we), 32'd0);
    tick();
    check("rd_valid_t1", 32'(b2.rsp_valid), 32'd0);
    tick();
    check("rd_valid_t2", 32'(b2.rsp_valid), 32'd0);
    tick();
    check("rd_valid_t3", 32'(b2.rsp_valid), 32'd1);
    check("rd_rdata", b2.rsp_rdata, 32'h0000_00CC);
    check("rd_rsp_we", 32'(b2.rsp_we), 32'd0);
    b2.rsp_ready = 1'b1;
    tick();
    check("rd_done", 32'(b2.rsp_valid), 32'd0);

    // back-to-back write then read, rsp_ready tied high
    we_base = we_cnt2;
    req2(1'b1, 24'h000200, 32'h1111_2222);
    tick();
    req2(1'b0, 24'h000004, 32'h0);
    check("b2b_ready_t1", 32'(b2.req_ready), 32'd0);
    tick();
    check("b2b_ready_t2", 32'(b2.req_ready), 32'd0);
    tick();
    check("b2b_ready_t3", 32'(b2.req_ready), 32'd1);
    tick();
    b2.req_valid = 1'b0;
    check("b2b_rd_busy", 32'(b2.busy), 32'd1);
    check("b2b_rd_addr", 32'(b2.gb_addr), 32'h000004);
    repeat (3) tick();
    check("b2b_rd_valid", 32'(b2.rsp_valid), 32'd1);
    check("b2b_rd_rdata", b2.rsp_rdata, 32'h0000_00CC);
    tick();
    check("b2b_ready_end", 32'(b2.req_ready), 32'd1);
    check("b2b_one_we", 32'(we_cnt2 - we_base), 32'd1);
    b2.rsp_ready = 1'b0;

    // stall in RESP with rsp_ready low for 10 cycles
    req2(1'b0, 24'h000008, 32'h0);
    tick();
    req2(1'b1, 24'h000300, 32'h3333_3333);
    repeat (3) tick();
    rsp_base = rsp_cnt2;
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 32'(b2.rsp_valid), 32'd1);
      check("stall_rdata", b2.rsp_rdata, 32'hA500_0008);
      check("stall_ready", 32'(b2.req_ready), 32'd0);
      check("stall_addr", 32'(b2.gb_addr), 32'h000008);
      tick();
    end
    b2.req_valid = 1'b0;
    b2.rsp_ready = 1'b1;
    tick();
    b2.rsp_ready = 1'b0;
    check("stall_release", 32'(b2.rsp_valid), 32'd0);
    repeat (3) tick();
    check("stall_one_rsp", 32'(rsp_cnt2 - rsp_base), 32'd1);
    check("stall_no_we", 32'(we_cnt2 - we_base), 32'd1);

    // reset during RD
    req2(1'b0, 24'h00000C, 32'h0);
    tick();
    b2.req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("rstrd_valid", 32'(b2.rsp_valid), 32'd0);
    check("rstrd_we", 32'(b2.gb_we), 32'd0);
    check("rstrd_busy", 32'(b2.busy), 32'd0);
    check("rstrd_ready", 32'(b2.req_ready), 32'd0);
    rsp_base = rsp_cnt2;
    rst_n = 1'b1;
    repeat (4) tick();
    check("rstrd_no_rsp", 32'(b2.rsp_valid), 32'd0);
    check("rstrd_ready_after", 32'(b2.req_ready), 32'd1);
    req2(1'b0, 24'h000004, 32'h0);
    tick();
    b2.req_valid = 1'b0;
    repeat (3) tick();
    check("rstrd_fresh_valid", 32'(b2.rsp_valid), 32'd1);
    check("rstrd_fresh_rdata", b2.rsp_rdata, 32'h0000_00CC);
    b2.rsp_ready = 1'b1;
    tick();
    b2.rsp_ready = 1'b0;
    check("rstrd_rsp_count", 32'(rsp_cnt2 - rsp_base), 32'd1);

    // write after a read returns zero read data
    req2(1'b1, 24'h000400, 32'h0BAD_F00D);
    tick();
    b2.req_valid = 1'b0;
    tick();
    check("wr2_rsp_rdata", b2.rsp_rdata, 32'd0);
    check("wr2_rsp_we", 32'(b2.rsp_we), 32'd1);
    check("wr2_dout", b2.gb_dout, 32'h0BAD_F00D);
    b2.rsp_ready = 1'b1;
    tick();
    b2.rsp_ready = 1'b0;

    // RD_LAT=7 read
    b7.req_valid = 1'b1;
    b7.req_we    = 1'b0;
    b7.req_addr  = 24'h00FFFF;
    tick();
    b7.req_valid = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("lat7_wait", 32'(b7.rsp_valid), 32'd0);
    end
    tick();
    check("lat7_valid", 32'(b7.rsp_valid), 32'd1);
    check("lat7_rdata", b7.rsp_rdata, 32'hA500_FFFF);
    b7.rsp_ready = 1'b1;
    tick();
    b7.rsp_ready = 1'b0;
    check("lat7_done", 32'(b7.rsp_valid), 32'd0);
    check("lat7_ready", 32'(b7.req_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
